uart_tx: RTL

Serial UART transmitter: the transmit end of the team's half-duplex UART link. It accepts one parallel byte per valid/ready handshake and emits an asynchronous frame on a single line: start bit, data bits, optional parity, stop bit(s). Bit timing comes from an internal divider of the system clock. It sits between the host-side byte source and the line that feeds the team's UART receiver.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_if.sv | 23 ++
 rtl/uart_bit_timer.sv | 33 +++
 rtl/uart_tx.sv | 128 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Line levels are named so that the frame builder reads in protocol terms.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam logic UART_LINE_IDLE = 1'b1;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic uart_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the host-side source and the UART transmitter.
// The source drives valid/byte; the transmitter answers with ready.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);

  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_byte;
  logic                 tx_ready;

  modport master (
    output tx_valid,
    output tx_byte,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_byte,
    output tx_ready
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Divides clk down to serial bit periods: bit_done pulses on the last
// cycle of every CLKS_PER_BIT-cycle period while enabled.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_bit_timer: CLKS_PER_BIT must be >= 2");
  end

  localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign bit_done = enable && (cnt_q == CNT_MAX);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= bit_done ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts one word per valid/ready handshake and sends
// start, data, optional parity and stop bits on a registered, idle-high line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int MSB_FIRST    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   tx_if,
  output logic       tx_out,
  output logic       busy
);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be in 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  // One index register counts data bits, then is reused to count stop bits.
  localparam int               IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  uart_tx_state_e       state_q, state_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d, pos;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 tx_out_d, busy_d;
  logic                 ready, accept, bit_done;

  assign ready          = (state_q == IDLE) && !rst;
  assign tx_if.tx_ready = ready;
  assign accept         = tx_if.tx_valid && ready;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (state_q != IDLE),
    .bit_done(bit_done)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          data_d  = tx_if.tx_byte;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx_q == LAST_IDX) begin
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d   = STOP;
          bit_idx_d = '0;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (bit_idx_q == LAST_STOP) begin
            state_d = IDLE;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The line is registered, so it is driven from the level of the upcoming state.
    pos      = (MSB_FIRST != 0) ? (LAST_IDX - bit_idx_d) : bit_idx_d;
    tx_out_d = UART_LINE_IDLE;
    case (state_d)
      START:   tx_out_d = UART_START_BIT;
      DATA:    tx_out_d = data_d[pos];
      PARITY:  tx_out_d = uart_parity(8'(data_d), PARITY_ODD != 0);
      STOP:    tx_out_d = UART_STOP_BIT;
      default: tx_out_d = UART_LINE_IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      data_q    <= '0;
      tx_out    <= UART_LINE_IDLE;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      tx_out    <= tx_out_d;
      busy      <= busy_d;
    end
  end

endmodule
